// File: rtl/fifo_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared types and helpers for the FIFO pointer/flag controller.
//   op_e     : the accepted operation of a cycle, encoded as {wr_ok, rd_ok}
//   ptr_inc  : next value of a wrapping pointer for an arbitrary (non power of
//              two) depth; wraps DEPTH-1 -> 0 by explicit compare
// ----------------------------------------------------------------------------
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        NOP        = 2'b00,
        READ       = 2'b01,
        WRITE      = 2'b10,
        READ_WRITE = 2'b11
    } op_e;

    // The >= form also walks an out-of-range pointer back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 1) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// ----------------------------------------------------------------------------
// fifo_ptr_wrap
// Wrapping pointer counter, 0 .. DEPTH-1, for arbitrary DEPTH.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (pointer -> 0)
//   inc      in   advance pointer by one on the next edge
//   clr      in   synchronous clear, wins over inc
//   ptr      out  current pointer (registered)
// ----------------------------------------------------------------------------
module fifo_ptr_wrap
    import fifo_ctrl_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = AW'(ptr_inc(32'(ptr_reg), DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl_param.sv
// ----------------------------------------------------------------------------
// fifo_ctrl_param
// FIFO pointer/flag controller for a separate dual-port register file of
// arbitrary DEPTH. Produces qualified RAM enables, addresses, occupancy count,
// full/empty/almost flags and overflow/underflow reporting.
//
// Build option: define FIFO_CTRL_STICKY_ERR_EN to make overflow/underflow
// sticky (cleared by err_clr or reset). Otherwise they are one-cycle pulses.
//
// Ports:
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   rd, wr        in   read / write requests
//   flush         in   synchronous clear, highest priority
//   af_thresh     in   almost_full threshold  (count >= af_thresh)
//   ae_thresh     in   almost_empty threshold (count <= ae_thresh)
//   err_clr       in   clears sticky error flags (sticky build only)
//   r_addr/w_addr out  read / write pointers
//   rd_en/wr_en   out  qualified read / write, combinational from inputs
//   count         out  occupancy 0..DEPTH
//   empty/full, almost_empty/almost_full  out  status flags from registered count
//   overflow/underflow                    out  rejected write / read (registered)
// ----------------------------------------------------------------------------
module fifo_ctrl_param
    import fifo_ctrl_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int DATA_WIDTH = 8,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rd,
    input  logic          wr,
    input  logic          flush,
    input  logic [CW-1:0] af_thresh,
    input  logic [CW-1:0] ae_thresh,
    input  logic          err_clr,
    output logic [AW-1:0] r_addr,
    output logic [AW-1:0] w_addr,
    output logic          rd_en,
    output logic          wr_en,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_empty,
    output logic          almost_full,
    output logic          overflow,
    output logic          underflow
);

    // Storage width does not influence control; kept for a uniform parameter set.
    localparam int DATA_WIDTH_UNUSED = DATA_WIDTH;

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic          overflow_next;
    logic          underflow_reg;
    logic          underflow_next;
    logic          rd_ok;
    logic          wr_ok;
    logic          ovf_evt;
    logic          unf_evt;
    op_e           op;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // When full, a simultaneous read frees the slot being written: the storage
    // reads the old entry before the write lands at the same address.
    assign rd_ok = rd & ~empty & ~flush;
    assign wr_ok = wr & ~flush & (~full | rd);

    assign ovf_evt = wr & ~wr_ok & ~flush;
    assign unf_evt = rd & ~rd_ok & ~flush;

    assign op = op_e'({wr_ok, rd_ok});

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            case (op)
                WRITE:   count_next = count_reg + CW'(1);
                READ:    count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

`ifdef FIFO_CTRL_STICKY_ERR_EN
    // Set wins over clear; flush leaves recorded errors alone.
    always_comb begin
        overflow_next  = ovf_evt | (overflow_reg  & ~err_clr);
        underflow_next = unf_evt | (underflow_reg & ~err_clr);
    end
`else
    logic err_clr_unused;
    assign err_clr_unused = err_clr;

    always_comb begin
        overflow_next  = ovf_evt;
        underflow_next = unf_evt;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Index 0 is the read pointer, index 1 the write pointer.
    logic [1:0]    ptr_adv;
    logic [AW-1:0] ptr_val [2];

    assign ptr_adv = {wr_ok, rd_ok};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
            fifo_ptr_wrap #(
                .DEPTH (DEPTH)
            ) u_ptr (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (ptr_adv[gi]),
                .clr     (flush),
                .ptr     (ptr_val[gi])
            );
        end
    endgenerate

    assign r_addr       = ptr_val[0];
    assign w_addr       = ptr_val[1];
    assign rd_en        = rd_ok;
    assign wr_en        = wr_ok;
    assign count        = count_reg;
    assign almost_empty = (count_reg <= ae_thresh);
    assign almost_full  = (count_reg >= af_thresh);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// ----------------------------------------------------------------------------
// tb_fifo_ctrl_param
// Directed scenarios followed by a randomized burst, all compared against a
// behavioural occupancy/pointer model. Honours FIFO_CTRL_STICKY_ERR_EN so the
// same bench covers both error-flag builds.
// ----------------------------------------------------------------------------
module tb_fifo_ctrl_param;

    localparam int DEPTH = 5;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rd, wr, flush, err_clr;
    logic [CW-1:0] af_thresh, ae_thresh;
    logic [AW-1:0] r_addr, w_addr;
    logic          rd_en, wr_en;
    logic [CW-1:0] count;
    logic          empty, full, almost_empty, almost_full;
    logic          overflow, underflow;

    fifo_ctrl_param #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rd           (rd),
        .wr           (wr),
        .flush        (flush),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .err_clr      (err_clr),
        .r_addr       (r_addr),
        .w_addr       (w_addr),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: occupancy and pointer positions as plain integers.
    int m_cnt = 0;
    int m_rp  = 0;
    int m_wp  = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_rp  = 0;
        m_wp  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_state(input string ctx);
        chk({ctx, ":count"},        32'(count),        m_cnt);
        chk({ctx, ":r_addr"},       32'(r_addr),       m_rp);
        chk({ctx, ":w_addr"},       32'(w_addr),       m_wp);
        chk({ctx, ":empty"},        32'(empty),        32'(m_cnt == 0));
        chk({ctx, ":full"},         32'(full),         32'(m_cnt == DEPTH));
        chk({ctx, ":almost_empty"}, 32'(almost_empty), 32'(m_cnt <= int'(ae_thresh)));
        chk({ctx, ":almost_full"},  32'(almost_full),  32'(m_cnt >= int'(af_thresh)));
        chk({ctx, ":overflow"},     32'(overflow),     32'(m_ovf));
        chk({ctx, ":underflow"},    32'(underflow),    32'(m_unf));
    endtask

    // One clock of stimulus: enables are checked before the edge, state after.
    task automatic step(input string ctx, input bit r, input bit w, input bit f, input bit ec);
        bit exp_rd, exp_wr, evt_o, evt_u;
        @(negedge clk);
        rd      = r;
        wr      = w;
        flush   = f;
        err_clr = ec;
        #1;
        exp_rd = r && (m_cnt > 0) && !f;
        exp_wr = w && !f && ((m_cnt < DEPTH) || r);
        chk({ctx, ":rd_en"}, 32'(rd_en), 32'(exp_rd));
        chk({ctx, ":wr_en"}, 32'(wr_en), 32'(exp_wr));
        evt_o = w && !exp_wr && !f;
        evt_u = r && !exp_rd && !f;
        if (f) begin
            m_cnt = 0;
            m_rp  = 0;
            m_wp  = 0;
        end else begin
            if (exp_rd) m_rp = (m_rp + 1) % DEPTH;
            if (exp_wr) m_wp = (m_wp + 1) % DEPTH;
            m_cnt = m_cnt + int'(exp_wr) - int'(exp_rd);
        end
`ifdef FIFO_CTRL_STICKY_ERR_EN
        m_ovf = evt_o || (m_ovf && !ec);
        m_unf = evt_u || (m_unf && !ec);
`else
        m_ovf = evt_o;
        m_unf = evt_u;
`endif
        @(posedge clk);
        #1;
        check_state(ctx);
        $display("step %-10s rd=%0b wr=%0b flush=%0b clr=%0b -> count=%0d r=%0d w=%0d ovf=%0b unf=%0b",
                 ctx, r, w, f, ec, count, r_addr, w_addr, overflow, underflow);
    endtask

    initial begin
        reset_n   = 1'b0;
        rd        = 1'b0;
        wr        = 1'b0;
        flush     = 1'b0;
        err_clr   = 1'b0;
        af_thresh = '0;
        ae_thresh = CW'(1);
        model_reset();
        #12;
        check_state("reset");
        @(negedge clk);
        reset_n   = 1'b1;
        af_thresh = CW'(4);

        // Fill to full, write pointer wraps 4 -> 0, then one rejected write.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, 1'b0);
        step("ovf", 1'b0, 1'b1, 1'b0, 1'b0);
        step("ovf_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        // Full with simultaneous read and write.
        step("full_rw", 1'b1, 1'b1, 1'b0, 1'b0);
        step("clr_err", 1'b0, 1'b0, 1'b0, 1'b1);

        // Drain, then empty with read+write, then lone read on empty.
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b1, 1'b0, 1'b0, 1'b0);
        step("empty_rw", 1'b1, 1'b1, 1'b0, 1'b0);
        step("rd_last", 1'b1, 1'b0, 1'b0, 1'b0);
        step("unf", 1'b1, 1'b0, 1'b0, 1'b0);
        step("clr_err", 1'b0, 1'b0, 1'b0, 1'b1);

        // Threshold crossings on the way 0 -> 4.
        af_thresh = CW'(3);
        ae_thresh = CW'(1);
        step("flush0", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("thresh", 1'b0, 1'b1, 1'b0, 1'b0);

        // Flush at count 3 with rd+wr requested.
        step("to3", 1'b1, 1'b0, 1'b0, 1'b0);
        step("flush_rw", 1'b1, 1'b1, 1'b1, 1'b0);

        // Randomized traffic with drifting thresholds and a mid-burst reset.
        for (int i = 0; i < 400; i++) begin
            bit r, w, f, ec;
            if (i % 37 == 0) begin
                af_thresh = CW'($urandom_range(0, (1 << CW) - 1));
                ae_thresh = CW'($urandom_range(0, (1 << CW) - 1));
            end
            if (i == 200) begin
                @(negedge clk);
                rd = 1'b1;
                wr = 1'b1;
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                check_state("async_rst");
                @(negedge clk);
                rd      = 1'b0;
                wr      = 1'b0;
                reset_n = 1'b1;
            end
            // Alternate write-heavy and read-heavy phases to reach both ends.
            if ((i / 40) % 2 == 0) begin
                w = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < 35);
            end else begin
                w = ($urandom_range(0, 99) < 35);
                r = ($urandom_range(0, 99) < 75);
            end
            f  = ($urandom_range(0, 99) < 4);
            ec = ($urandom_range(0, 99) < 10);
            step("rand", r, w, f, ec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
